flash_cmd_sequencer: RTL



---
 rtl/flash_cmd_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command sequencer in front of the PRG flash write-enable gate.
// Passes only well-formed unlock/program/erase/autoselect writes and times the busy window.
module flash_cmd_sequencer #(
    parameter int unsigned PROG_CYCLES  = 64,
    parameter int unsigned ERASE_CYCLES = 24'd4000000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        cpu_wr_strobe,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        prg_write_enabled,
    input  logic        clear_error,
    output logic        we_allow,
    output logic        busy,
    output logic [3:0]  seq_state,
    output logic        cmd_error
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_U1      = 4'd1,
        S_U2      = 4'd2,
        S_PROG    = 4'd3,
        S_E_SETUP = 4'd4,
        S_E_U1    = 4'd5,
        S_E_U2    = 4'd6,
        S_BUSY    = 4'd7,
        S_AUTOSEL = 4'd8
    } state_t;

    // Counter is loaded with N-1 so busy stays high for exactly N cycles.
    localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_err;

    state_t             w_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_allow;
    logic               w_hit;
    logic               w_err_event;
    logic               w_at_aaa;
    logic               w_at_555;

    assign w_at_aaa = (cpu_addr == 12'hAAA);
    assign w_at_555 = (cpu_addr == 12'h555);

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_allow     = 1'b0;
        w_hit       = 1'b0;
        w_err_event = 1'b0;
        if (r_state == S_BUSY) begin
            // Countdown runs regardless of the write-enable bit.
            if (r_cnt == '0) begin
                w_next = S_IDLE;
            end else begin
                w_cnt_next = r_cnt - 1'b1;
            end
            if (cpu_wr_strobe && prg_write_enabled) begin
                w_err_event = 1'b1;
            end
        end else if (!prg_write_enabled) begin
            w_next = S_IDLE;
        end else if (cpu_wr_strobe) begin
            case (r_state)
                S_IDLE: begin
                    if (w_at_aaa && cpu_data == 8'hAA) begin
                        w_hit  = 1'b1;
                        w_next = S_U1;
                    end
                end
                S_U1: begin
                    if (w_at_555 && cpu_data == 8'h55) begin
                        w_hit  = 1'b1;
                        w_next = S_U2;
                    end
                end
                S_U2: begin
                    if (w_at_aaa && cpu_data == 8'hA0) begin
                        w_hit  = 1'b1;
                        w_next = S_PROG;
                    end else if (w_at_aaa && cpu_data == 8'h80) begin
                        w_hit  = 1'b1;
                        w_next = S_E_SETUP;
                    end else if (w_at_aaa && cpu_data == 8'h90) begin
                        w_hit  = 1'b1;
                        w_next = S_AUTOSEL;
                    end
                end
                S_PROG: begin
                    // The program data itself may be any byte, F0 included.
                    w_hit      = 1'b1;
                    w_next     = S_BUSY;
                    w_cnt_next = PROG_LOAD;
                end
                S_E_SETUP: begin
                    if (w_at_aaa && cpu_data == 8'hAA) begin
                        w_hit  = 1'b1;
                        w_next = S_E_U1;
                    end
                end
                S_E_U1: begin
                    if (w_at_555 && cpu_data == 8'h55) begin
                        w_hit  = 1'b1;
                        w_next = S_E_U2;
                    end
                end
                S_E_U2: begin
                    if (cpu_data == 8'h30 || (w_at_aaa && cpu_data == 8'h10)) begin
                        w_hit      = 1'b1;
                        w_next     = S_BUSY;
                        w_cnt_next = ERASE_LOAD;
                    end
                end
                default: begin
                end
            endcase

            if (w_hit) begin
                w_allow = 1'b1;
            end else if (cpu_data == 8'hF0) begin
                w_allow = 1'b1;
                w_next  = S_IDLE;
            end else if (r_state != S_AUTOSEL) begin
                w_next      = S_IDLE;
                w_err_event = 1'b1;
            end
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_next == S_BUSY);
            r_err   <= w_err_event | (r_err & ~clear_error);
        end
    end

    // Gated by rst_n so an in-reset strobe can never reach the flash.
    assign we_allow  = w_allow & rst_n;
    assign busy      = r_busy;
    assign seq_state = r_state;
    assign cmd_error = r_err;

endmodule
